// File: rtl/padctrl_pkg.sv
// Shared pad-control types and sizes.
// Used by the pad attribute sequencer and its neighbours.
package padctrl_pkg;

    localparam int NMioPads = 32;
    localparam int NDioPads = 15;
    localparam int AttrDw   = 10;
    localparam int IdxW     = 6;

    typedef logic [AttrDw-1:0] pad_attr_t;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SETTLE,
        RESP
    } attr_seq_state_e;

endpackage

// File: rtl/padctrl_attr_seq.sv
// Pad attribute sequencer: owns the MIO/DIO attribute registers, serves one register
// request at a time, and holds each write for a settle window before responding.
module padctrl_attr_seq
    import padctrl_pkg::*;
#(
    parameter int                SettleCycles = 4,
    parameter logic [AttrDw-1:0] AttrWarlMask = 10'h3FF
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       regen_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_write_i,
    input  logic                       req_dio_i,
    input  logic [IdxW-1:0]            req_idx_i,
    input  logic [AttrDw-1:0]          req_attr_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [AttrDw-1:0]          rsp_attr_o,
    output logic                       rsp_err_o,
    output logic                       busy_o,
    output logic [NMioPads*AttrDw-1:0] mio_attr_o,
    output logic [NDioPads*AttrDw-1:0] dio_attr_o
);

    localparam logic [IdxW-1:0] MioLimit = IdxW'(NMioPads);
    localparam logic [IdxW-1:0] DioLimit = IdxW'(NDioPads);
    localparam int              MioIw    = $clog2(NMioPads);
    localparam int              DioIw    = $clog2(NDioPads);
    // Counter counts down to zero, so a window of N cycles loads N-1.
    localparam logic [7:0]      SettleLoad = (SettleCycles == 0) ? 8'd0 : 8'(SettleCycles - 1);

    attr_seq_state_e state_q, state_d;

    logic            write_q;
    logic            dio_q;
    logic [IdxW-1:0] idx_q;
    pad_attr_t       attr_q;
    logic [7:0]      cnt_q;
    pad_attr_t       rsp_attr_q;
    logic            rsp_err_q;
    pad_attr_t       mio_regs [NMioPads];
    pad_attr_t       dio_regs [NDioPads];

    logic            idx_bad;
    logic            apply_err;
    pad_attr_t       cur_attr;

    always_comb begin
        idx_bad   = dio_q ? (idx_q >= DioLimit) : (idx_q >= MioLimit);
        apply_err = idx_bad || (write_q && !regen_i);
        cur_attr  = '0;
        if (!idx_bad) begin
            cur_attr = dio_q ? dio_regs[idx_q[DioIw-1:0]] : mio_regs[idx_q[MioIw-1:0]];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = APPLY;
            APPLY: begin
                if (apply_err || !write_q || (SettleCycles == 0)) state_d = RESP;
                else                                               state_d = SETTLE;
            end
            SETTLE:  if (cnt_q == 8'd0) state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            dio_q      <= 1'b0;
            idx_q      <= '0;
            attr_q     <= '0;
            cnt_q      <= '0;
            rsp_attr_q <= '0;
            rsp_err_q  <= 1'b0;
            for (int k = 0; k < NMioPads; k++) mio_regs[k] <= '0;
            for (int k = 0; k < NDioPads; k++) dio_regs[k] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        write_q <= req_write_i;
                        dio_q   <= req_dio_i;
                        idx_q   <= req_idx_i;
                        attr_q  <= req_attr_i & AttrWarlMask;
                    end
                end
                APPLY: begin
                    cnt_q     <= SettleLoad;
                    rsp_err_q <= apply_err;
                    if (apply_err)    rsp_attr_q <= '0;
                    else if (write_q) rsp_attr_q <= attr_q;
                    else              rsp_attr_q <= cur_attr;
                    if (write_q && !apply_err) begin
                        if (dio_q) dio_regs[idx_q[DioIw-1:0]] <= attr_q;
                        else       mio_regs[idx_q[MioIw-1:0]] <= attr_q;
                    end
                end
                SETTLE: begin
                    if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_attr_o  = rsp_attr_q;
    assign rsp_err_o   = rsp_err_q;

    for (genvar k = 0; k < NMioPads; k++) begin : gen_mio_flat
        assign mio_attr_o[k*AttrDw +: AttrDw] = mio_regs[k];
    end
    for (genvar k = 0; k < NDioPads; k++) begin : gen_dio_flat
        assign dio_attr_o[k*AttrDw +: AttrDw] = dio_regs[k];
    end

endmodule

// File: tb/tb_padctrl_attr_seq.sv
// Scoreboard bench for padctrl_attr_seq: three instances cover default settle, a narrow
// WARL mask and a zero-length settle window.
module tb_padctrl_attr_seq;

    logic         clk;
    logic         rst_n;
    logic         regen;
    logic         req_valid [3];
    logic         req_ready [3];
    logic         req_write [3];
    logic         req_dio   [3];
    logic [5:0]   req_idx   [3];
    logic [9:0]   req_attr  [3];
    logic         rsp_valid [3];
    logic         rsp_ready [3];
    logic [9:0]   rsp_attr  [3];
    logic         rsp_err   [3];
    logic         busy      [3];
    logic [319:0] mio       [3];
    logic [149:0] dio       [3];

    // Instance 0: SettleCycles=4, full mask; 1: mask 0FF; 2: SettleCycles=0.
    for (genvar g = 0; g < 3; g++) begin : gen_dut
        padctrl_attr_seq #(
            .SettleCycles (g == 2 ? 0 : 4),
            .AttrWarlMask (g == 1 ? 10'h0FF : 10'h3FF)
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .regen_i     (regen),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready[g]),
            .req_write_i (req_write[g]),
            .req_dio_i   (req_dio[g]),
            .req_idx_i   (req_idx[g]),
            .req_attr_i  (req_attr[g]),
            .rsp_valid_o (rsp_valid[g]),
            .rsp_ready_i (rsp_ready[g]),
            .rsp_attr_o  (rsp_attr[g]),
            .rsp_err_o   (rsp_err[g]),
            .busy_o      (busy[g]),
            .mio_attr_o  (mio[g]),
            .dio_attr_o  (dio[g])
        );
    end

    typedef struct {
        int         dut;
        logic [9:0] attr;
        logic       err;
        int         cyc;
        string      name;
    } exp_t;

    exp_t         sb [$];
    exp_t         mon_e;
    bit           seen [3];
    int           compared;
    int           mismatched;
    int           cyc;
    logic [319:0] exp_mio0;
    logic [149:0] exp_dio0;
    logic [319:0] exp_mio1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [479:0] act, input logic [479:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: on the first cycle of each response, pop the oldest expectation and compare.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rsp_valid[g] && !seen[g]) begin
                seen[g] = 1'b1;
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_rsp: dut%0d responded with nothing expected", g);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput({mon_e.name, "_dut"},  480'(g),             480'(mon_e.dut));
                    checkOutput({mon_e.name, "_attr"}, 480'(rsp_attr[g]),   480'(mon_e.attr));
                    checkOutput({mon_e.name, "_err"},  480'(rsp_err[g]),    480'(mon_e.err));
                    checkOutput({mon_e.name, "_cyc"},  480'(cyc),           480'(mon_e.cyc));
                end
            end else if (!rsp_valid[g]) begin
                seen[g] = 1'b0;
            end
        end
    end

    // Drives one request at a negedge; returns just after the accepting edge (cycle T+1).
    task automatic applyStimulus(input int g, input bit wr, input bit is_dio, input logic [5:0] idx,
                                 input logic [9:0] attr, input logic [9:0] exp_attr,
                                 input bit exp_err, input int lat, input string name);
        exp_t e;
        @(negedge clk);
        req_valid[g] = 1'b1;
        req_write[g] = wr;
        req_dio[g]   = is_dio;
        req_idx[g]   = idx;
        req_attr[g]  = attr;
        e.dut  = g;
        e.attr = exp_attr;
        e.err  = exp_err;
        e.cyc  = cyc + lat;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid[g] = 1'b0;
    endtask

    task automatic waitIdle(input int g);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!busy[g] && sb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL wait_idle: dut%0d busy=%0b pending=%0d, required idle", g, busy[g], sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        regen      = 1'b1;
        rst_n      = 1'b0;
        for (int g = 0; g < 3; g++) begin
            req_valid[g] = 1'b0;
            req_write[g] = 1'b0;
            req_dio[g]   = 1'b0;
            req_idx[g]   = '0;
            req_attr[g]  = '0;
            rsp_ready[g] = 1'b1;
        end
        exp_mio0 = '0;
        exp_dio0 = '0;
        exp_mio1 = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready", 480'(req_ready[0]), 480'(1));
        checkOutput("rst_rsp_valid", 480'(rsp_valid[0]), 480'(0));
        checkOutput("rst_busy",      480'(busy[0]),      480'(0));
        checkOutput("rst_rsp_attr",  480'(rsp_attr[0]),  480'(0));
        checkOutput("rst_rsp_err",   480'(rsp_err[0]),   480'(0));
        checkOutput("rst_mio",       480'(mio[0]),       480'(0));
        checkOutput("rst_dio",       480'(dio[0]),       480'(0));
        rst_n = 1'b1;

        applyStimulus(0, 0, 0, 6'd5, 10'h000, 10'h000, 0, 2, "rd_mio5");
        waitIdle(0);
        checkOutput("mio_zero", 480'(mio[0]), 480'(0));
        checkOutput("dio_zero", 480'(dio[0]), 480'(0));

        applyStimulus(0, 1, 0, 6'd31, 10'h2A5, 10'h2A5, 0, 6, "wr_mio31");
        @(negedge clk);
        checkOutput("wr_busy_t1",   480'(busy[0]), 480'(1));
        checkOutput("wr_mio_t1",    480'(mio[0]),  480'(0));
        exp_mio0[319:310] = 10'h2A5;
        @(negedge clk);
        checkOutput("wr_mio_t2",    480'(mio[0]),  480'(exp_mio0));
        checkOutput("wr_busy_t2",   480'(busy[0]), 480'(1));
        waitIdle(0);
        applyStimulus(0, 0, 0, 6'd31, 10'h000, 10'h2A5, 0, 2, "rd_mio31");
        waitIdle(0);

        regen = 1'b0;
        applyStimulus(0, 1, 1, 6'd3, 10'h3FF, 10'h000, 1, 2, "wr_locked");
        waitIdle(0);
        checkOutput("locked_dio", 480'(dio[0]), 480'(0));
        regen = 1'b1;

        applyStimulus(0, 0, 1, 6'd15, 10'h000, 10'h000, 1, 2, "rd_dio15");
        waitIdle(0);
        applyStimulus(0, 1, 0, 6'd40, 10'h111, 10'h000, 1, 2, "wr_mio40");
        waitIdle(0);
        checkOutput("oob_mio", 480'(mio[0]), 480'(exp_mio0));
        applyStimulus(0, 0, 1, 6'd14, 10'h000, 10'h000, 0, 2, "rd_dio14");
        waitIdle(0);
        applyStimulus(0, 1, 1, 6'd14, 10'h1C3, 10'h1C3, 0, 6, "wr_dio14");
        waitIdle(0);
        exp_dio0[149:140] = 10'h1C3;
        checkOutput("dio14_bus", 480'(dio[0]), 480'(exp_dio0));
        applyStimulus(0, 0, 1, 6'd14, 10'h000, 10'h1C3, 0, 2, "rd_dio14b");
        waitIdle(0);

        applyStimulus(1, 1, 0, 6'd7, 10'h3FF, 10'h0FF, 0, 6, "warl_wr");
        waitIdle(1);
        exp_mio1[79:70] = 10'h0FF;
        checkOutput("warl_bus", 480'(mio[1]), 480'(exp_mio1));
        applyStimulus(1, 0, 0, 6'd7, 10'h000, 10'h0FF, 0, 2, "warl_rd");
        waitIdle(1);

        applyStimulus(2, 1, 0, 6'd2, 10'h0AB, 10'h0AB, 0, 2, "s0_wr");
        waitIdle(2);

        applyStimulus(0, 1, 0, 6'd31, 10'h2A5, 10'h2A5, 0, 6, "same_wr");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("same_mio", 480'(mio[0]), 480'(exp_mio0));
        end
        waitIdle(0);

        applyStimulus(0, 1, 0, 6'd4, 10'h03C, 10'h03C, 0, 6, "regen_drop");
        @(negedge clk);
        @(negedge clk);
        regen = 1'b0;
        waitIdle(0);
        exp_mio0[49:40] = 10'h03C;
        checkOutput("regen_drop_bus", 480'(mio[0]), 480'(exp_mio0));
        regen = 1'b1;

        rsp_ready[0] = 1'b0;
        applyStimulus(0, 0, 0, 6'd31, 10'h000, 10'h2A5, 0, 2, "hold_rd");
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 480'(rsp_valid[0]), 480'(1));
            checkOutput("hold_attr",  480'(rsp_attr[0]),  480'(10'h2A5));
            checkOutput("hold_ready", 480'(req_ready[0]), 480'(0));
        end
        rsp_ready[0] = 1'b1;
        waitIdle(0);

        applyStimulus(0, 1, 0, 6'd0, 10'h155, 10'h155, 0, 6, "rst_mid");
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_mid_pre", 480'(mio[0][9:0]), 480'(10'h155));
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        checkOutput("rst_mid_mio",   480'(mio[0]),       480'(0));
        checkOutput("rst_mid_busy",  480'(busy[0]),      480'(0));
        checkOutput("rst_mid_ready", 480'(req_ready[0]), 480'(1));
        checkOutput("rst_mid_valid", 480'(rsp_valid[0]), 480'(0));
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 6'd0, 10'h000, 10'h000, 0, 2, "post_rst_rd0");
        waitIdle(0);
        applyStimulus(0, 0, 0, 6'd31, 10'h000, 10'h000, 0, 2, "post_rst_rd31");
        waitIdle(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
